// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART TX scheduler
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        START,
        RUN,
        REL
    } state_e;

    localparam int DW_DEF = 10;
    localparam int BW_DEF = 20;

    localparam logic MODE_8B  = 1'b0;
    localparam logic MODE_10B = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at rr and wraps
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one apb_tx among N_REQ requesters
// Optional stall timeout (err port, TO_CYC) built when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DW     = DW_DEF,
    parameter int BW     = BW_DEF,
    parameter int TO_W   = 16,
`ifdef UART_TX_SCHED_TIMEOUT_EN
    parameter int TO_CYC = 65535,
`endif
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_din,
    input  logic [N_REQ*BW-1:0] req_baud,
    input  logic [N_REQ-1:0]    req_mode,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    done,
    output logic                tx_sel,
    output logic                tx_set,
    output logic                tx_mode,
    output logic [DW-1:0]       tx_din,
    output logic [BW-1:0]       tx_baud,
    input  logic                tx_en,
    output logic                busy,
    output logic [IW-1:0]       owner
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    output logic [N_REQ-1:0]    err
`endif
);

    if (N_REQ < 1 || N_REQ > 8 || TO_W < 1) begin : g_bad_param
        $error("uart_tx_sched: unsupported parameter set");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [DW-1:0]    din_q, din_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic             mode_q, mode_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             sel_q, sel_d;
    logic             set_q, set_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_vld;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             to_hit;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req),
        .rr      (rr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        din_d   = din_q;
        baud_d  = baud_q;
        mode_d  = mode_q;
        ack_d   = '0;
        done_d  = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
        to_hit  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = LOAD;
                    owner_d = arb_idx;
                    ack_d   = arb_gnt;
                    if (int'(arb_idx) == N_REQ - 1) rr_d = '0;
                    else                            rr_d = arb_idx + 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            din_d  = req_din[i*DW +: DW];
                            baud_d = req_baud[i*BW +: BW];
                            mode_d = (req_mode[i] == MODE_10B) ? MODE_10B : MODE_8B;
                        end
                    end
                end
            end
            LOAD:    state_d = GAP;
            GAP:     state_d = START;
            START:   if (tx_en)  state_d = RUN;
            RUN:     if (!tx_en) state_d = REL;
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Counter restarts on every entry to START or RUN; a stall in either forces REL.
        if (state_q == START || state_q == RUN) begin
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q == TO_W'(TO_CYC - 1)) begin
                state_d = REL;
                to_hit  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_d == START) begin
            cnt_d = '0;
        end
`endif

        if (state_d == REL) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (int'(owner_q) == i) begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    err_d[i]  = to_hit;
                    done_d[i] = !to_hit;
`else
                    done_d[i] = 1'b1;
`endif
                end
            end
        end

        sel_d  = (state_d == LOAD) || (state_d == START) || (state_d == RUN);
        set_d  = (state_d == START) || (state_d == RUN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            din_q   <= '0;
            baud_q  <= '0;
            mode_q  <= MODE_8B;
            ack_q   <= '0;
            done_q  <= '0;
            sel_q   <= 1'b0;
            set_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            din_q   <= din_d;
            baud_q  <= baud_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            set_q   <= set_d;
            busy_q  <= busy_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign tx_sel  = sel_q;
    assign tx_set  = set_q;
    assign tx_mode = mode_q;
    assign tx_din  = din_q;
    assign tx_baud = baud_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign err     = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched (UART_TX_SCHED_TIMEOUT_EN adds timeout test)
module tb_uart_tx_sched;
    import uart_tx_pkg::*;

    localparam int N_REQ = 4;
    localparam int DW    = 10;
    localparam int BW    = 20;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int LONG_LEN = 40;
`else
    localparam int LONG_LEN = 100;
`endif

    logic                clk = 1'b0;
    logic                rstn;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_din;
    logic [N_REQ*BW-1:0] req_baud;
    logic [N_REQ-1:0]    req_mode;
    logic [N_REQ-1:0]    ack, done;
    logic                tx_sel, tx_set, tx_mode, tx_en, busy;
    logic [DW-1:0]       tx_din;
    logic [BW-1:0]       tx_baud;
    logic [1:0]          owner;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [N_REQ-1:0]    err;
`endif

    typedef struct {
        int            idx;
        logic [DW-1:0] din;
        logic [BW-1:0] baud;
        logic          mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ (N_REQ),
        .DW    (DW),
        .BW    (BW),
        .TO_W  (16)
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ,
        .TO_CYC(50)
`endif
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .req_din  (req_din),
        .req_baud (req_baud),
        .req_mode (req_mode),
        .ack      (ack),
        .done     (done),
        .tx_sel   (tx_sel),
        .tx_set   (tx_set),
        .tx_mode  (tx_mode),
        .tx_din   (tx_din),
        .tx_baud  (tx_baud),
        .tx_en    (tx_en),
        .busy     (busy),
        .owner    (owner)
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ,
        .err      (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int i, input logic [DW-1:0] d, input logic [BW-1:0] b, input logic m);
        req_din[i*DW +: DW]  = d;
        req_baud[i*BW +: BW] = b;
        req_mode[i]          = m;
    endtask

    task automatic post_req(input int i, input logic [DW-1:0] d, input logic [BW-1:0] b, input logic m);
        set_cfg(i, d, b, m);
        req[i] = 1'b1;
        sb_q.push_back('{idx: i, din: d, baud: b, mode: m});
    endtask

    task automatic wait_grant(input string tag, output exp_t e, output bit ok);
        bit got;
        got = 1'b0;
        ok  = 1'b0;
        e   = '{idx: 0, din: '0, baud: '0, mode: 1'b0};
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk($sformatf("%s_ack_timeout", tag), 32'd0, 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk($sformatf("%s_unexpected_ack", tag), 32'(ack), 32'd0);
            return;
        end
        e  = sb_q.pop_front();
        ok = 1'b1;
        chk($sformatf("%s_ack", tag),   32'(ack),     32'd1 << e.idx);
        chk($sformatf("%s_owner", tag), 32'(owner),   32'(e.idx));
        chk($sformatf("%s_din", tag),   32'(tx_din),  32'(e.din));
        chk($sformatf("%s_baud", tag),  32'(tx_baud), 32'(e.baud));
        chk($sformatf("%s_mode", tag),  32'(tx_mode), 32'(e.mode));
        chk($sformatf("%s_load", tag),  {29'd0, busy, tx_sel, tx_set}, 32'b110);
    endtask

    task automatic run_frame(input string tag, input int len, input bit drop, input bit mutate,
                             input int pulse_idx);
        exp_t e;
        bit   ok;
        wait_grant(tag, e, ok);
        if (!ok) return;
        if (drop)   req[e.idx] = 1'b0;
        if (mutate) set_cfg(e.idx, ~e.din, e.baud + 20'd1, ~e.mode);
        @(negedge clk);
        chk($sformatf("%s_gap", tag), {30'd0, tx_sel, tx_set}, 32'b00);
        @(negedge clk);
        chk($sformatf("%s_start", tag), {30'd0, tx_sel, tx_set}, 32'b11);
        chk($sformatf("%s_start_hold", tag), {tx_mode, tx_baud, tx_din}, {e.mode, e.baud, e.din});
        tx_en = 1'b1;
        for (int c = 0; c < len; c++) begin
            if (pulse_idx >= 0 && c == 0) req[pulse_idx] = 1'b1;
            if (pulse_idx >= 0 && c == 2) req[pulse_idx] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("%s_run", tag), {28'd0, done, tx_sel, tx_set}, 32'b11);
        chk($sformatf("%s_run_hold", tag), {tx_mode, tx_baud, tx_din}, {e.mode, e.baud, e.din});
        tx_en = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_rel_done", tag), 32'(done), 32'd1 << e.idx);
        chk($sformatf("%s_rel_out", tag), {29'd0, busy, tx_sel, tx_set}, 32'b100);
        chk($sformatf("%s_rel_hold", tag), {tx_mode, tx_baud, tx_din}, {e.mode, e.baud, e.din});
        @(negedge clk);
        chk($sformatf("%s_idle", tag), {27'd0, done, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   ok;
        int   seen;

        rstn     = 1'b0;
        req      = '0;
        req_din  = '0;
        req_baud = '0;
        req_mode = '0;
        tx_en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {ack, done, 2'(owner), busy, tx_sel, tx_set}, 32'd0);
        chk("rst_data", {tx_mode, tx_baud, tx_din}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // single request, long frame
        post_req(0, 10'h035, 20'd16, MODE_8B);
        run_frame("single", LONG_LEN, 1'b1, 1'b0, -1);

        // config hold while requester changes inputs after ack (rr -> 3)
        post_req(2, 10'h30A, 20'd20, MODE_10B);
        run_frame("hold", 6, 1'b1, 1'b1, -1);

        // wrap from rr=3 to requester 1, leaving rr=2
        post_req(1, 10'h0F1, 20'd0, MODE_8B);
        run_frame("wrap", 4, 1'b1, 1'b0, -1);

        // rr=2: requester 3 must beat requester 0; requester 1 pulses and withdraws
        post_req(3, 10'h2AA, 20'd33, MODE_10B);
        post_req(0, 10'h155, 20'd5, MODE_8B);
        run_frame("rr3", 4, 1'b1, 1'b0, -1);
        run_frame("rr0", 5, 1'b1, 1'b0, 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack != '0) seen++;
        end
        chk("withdraw_no_ack", 32'(seen), 32'd0);

        // reset mid-frame during RUN
        post_req(2, 10'h1C3, 20'd7, MODE_10B);
        wait_grant("midrst", e, ok);
        req[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_run", {30'd0, tx_sel, tx_set}, 32'b11);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ctrl", {ack, done, 2'(owner), busy, tx_sel, tx_set}, 32'd0);
        chk("midrst_data", {tx_mode, tx_baud, tx_din}, 32'd0);
        tx_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != '0 || busy) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        // fairness with all requests held: 0,1,2,3,0
        post_req(0, 10'h011, 20'd100, MODE_8B);
        post_req(1, 10'h122, 20'd200, MODE_10B);
        post_req(2, 10'h233, 20'd300, MODE_8B);
        post_req(3, 10'h344, 20'd400, MODE_10B);
        sb_q.push_back('{idx: 0, din: 10'h011, baud: 20'd100, mode: MODE_8B});
        for (int k = 0; k < 5; k++) run_frame($sformatf("fair%0d", k), 3, 1'b0, 1'b0, -1);
        req = '0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // stuck transmitter: tx_en never rises
        post_req(1, 10'h2F0, 20'd9, MODE_10B);
        wait_grant("to", e, ok);
        req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("to_start", {30'd0, tx_sel, tx_set}, 32'b11);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            seen++;
            if (err != '0) break;
        end
        chk("to_latency", 32'(seen), 32'd50);
        chk("to_err", 32'(err), 32'b0010);
        chk("to_no_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("to_idle", {28'd0, err, busy}, 32'd0);
`endif

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
